mpmc11_rd_strip_collect: RTL and testbench

Read-data side of the mpmc11 strip burst engine. It receives read-return beats (one strip per beat) from the DDR app interface for a request of num_strips+1 strips. It tags each beat with its strip index and 32-byte-aligned address, and writes it to the read line buffer. It pulses done when the last strip has landed, closing the request started when the address generator issued its bursts.

---
 rtl/mpmc11_rd_strip_collect_if.sv | 35 +++
 rtl/mpmc11_rd_strip_collect.sv | 183 ++++++++++++++++++
 tb/tb_mpmc11_rd_strip_collect.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mpmc11_rd_strip_collect_if.sv
// rtl/mpmc11_rd_strip_collect_if.sv - request, read-return and line-buffer write bundle for the strip collector
interface mpmc11_rd_strip_collect_if #(
  parameter int DATA_WIDTH = 256
);
  // request side
  logic                  start;
  logic [5:0]            num_strips;
  logic [31:0]           addr_base;
  // DDR app read-return side
  logic                  app_rd_data_valid;
  logic [DATA_WIDTH-1:0] app_rd_data;
  // line-buffer write side and status
  logic [5:0]            strip_cnt;
  logic                  rd_we;
  logic [5:0]            rd_strip;
  logic [31:0]           rd_adr;
  logic [DATA_WIDTH-1:0] rd_dat;
  logic                  busy;
  logic                  done;
  logic                  err_start;
  logic                  err_stray;
  logic                  err_timeout;

  modport master (
    output start, num_strips, addr_base, app_rd_data_valid, app_rd_data,
    input  strip_cnt, rd_we, rd_strip, rd_adr, rd_dat, busy, done,
           err_start, err_stray, err_timeout
  );

  modport slave (
    input  start, num_strips, addr_base, app_rd_data_valid, app_rd_data,
    output strip_cnt, rd_we, rd_strip, rd_adr, rd_dat, busy, done,
           err_start, err_stray, err_timeout
  );
endinterface

// File: rtl/mpmc11_rd_strip_collect.sv
// rtl/mpmc11_rd_strip_collect.sv - tags read-return strips with index/address and writes them to the line buffer (optional watchdog: MPMC11_RD_TIMEOUT_EN)
module mpmc11_rd_strip_collect #(
  parameter int DATA_WIDTH = 256,
  parameter int TIMEOUT    = 1023
) (
  input  logic                      clk,
  input  logic                      rst,
  mpmc11_rd_strip_collect_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [5:0]            ns_q, ns_d;
  logic [26:0]           base_q, base_d;
  logic [5:0]            strip_cnt_q, strip_cnt_d;
  logic                  rd_we_q, rd_we_d;
  logic [5:0]            rd_strip_q, rd_strip_d;
  logic [31:0]           rd_adr_q, rd_adr_d;
  logic [DATA_WIDTH-1:0] rd_dat_q, rd_dat_d;
  logic                  err_start_q, err_start_d;
  logic                  err_stray_q, err_stray_d;

  logic                  accept_start;
  logic                  accept_beat;
  logic                  last_beat;
  logic                  timeout_hit;
  logic [26:0]           adr_sum;

  // a start is only taken outside COLLECT; beats only count inside it
  assign accept_start = bus.start && (state_q != S_COLLECT);
  assign accept_beat  = bus.app_rd_data_valid && (state_q == S_COLLECT);
  assign last_beat    = accept_beat && (strip_cnt_q == ns_q);
  // 27-bit line address, wraps modulo 2^27 without touching the byte offset
  assign adr_sum      = base_q + 27'(strip_cnt_q);

`ifdef MPMC11_RD_TIMEOUT_EN
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          err_timeout_q, err_timeout_d;

  // the TIMEOUT-th consecutive idle COLLECT cycle abandons the request
  assign timeout_hit = (state_q == S_COLLECT) && !bus.app_rd_data_valid &&
                       (tmo_cnt_q == TW'(TIMEOUT - 1));

  // watchdog: cleared on entry and on every beat, counts idle COLLECT cycles
  always_comb begin
    tmo_cnt_d     = tmo_cnt_q;
    err_timeout_d = err_timeout_q;
    if (accept_start || accept_beat) begin
      tmo_cnt_d = '0;
    end else if (state_q == S_COLLECT) begin
      tmo_cnt_d = tmo_cnt_q + TW'(1);
    end
    if (accept_start) begin
      err_timeout_d = 1'b0;
    end
    if (timeout_hit) begin
      err_timeout_d = 1'b1;
    end
  end

  // watchdog registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt_q     <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q     <= tmo_cnt_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign bus.err_timeout = err_timeout_q;
`else
  assign timeout_hit     = 1'b0;
  assign bus.err_timeout = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next state: DONE lasts one cycle and may chain straight into a new request
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (bus.start) state_d = S_COLLECT;
      S_COLLECT: if (last_beat || timeout_hit) state_d = S_DONE;
      S_DONE:    state_d = bus.start ? S_COLLECT : S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // request latching, beat tagging and sticky error flags
  always_comb begin
    ns_d        = ns_q;
    base_d      = base_q;
    strip_cnt_d = strip_cnt_q;
    rd_we_d     = 1'b0;
    rd_strip_d  = rd_strip_q;
    rd_adr_d    = rd_adr_q;
    rd_dat_d    = rd_dat_q;
    err_start_d = err_start_q;
    err_stray_d = err_stray_q;

    if (accept_start) begin
      ns_d        = bus.num_strips;
      base_d      = bus.addr_base[31:5];
      strip_cnt_d = 6'd0;
      err_start_d = 1'b0;
      err_stray_d = 1'b0;
    end

    if (accept_beat) begin
      rd_we_d    = 1'b1;
      rd_strip_d = strip_cnt_q;
      rd_adr_d   = {adr_sum, 5'h00};
      rd_dat_d   = bus.app_rd_data;
      // the final index is held so strip_cnt never wraps past num_strips
      if (!last_beat) begin
        strip_cnt_d = strip_cnt_q + 6'd1;
      end
    end

    if (bus.start && (state_q == S_COLLECT)) begin
      err_start_d = 1'b1;
    end
    // a stray beat wins over the clear from a start in the same cycle
    if (bus.app_rd_data_valid && (state_q != S_COLLECT)) begin
      err_stray_d = 1'b1;
    end
  end

  // datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ns_q        <= 6'd0;
      base_q      <= 27'd0;
      strip_cnt_q <= 6'd0;
      rd_we_q     <= 1'b0;
      rd_strip_q  <= 6'd0;
      rd_adr_q    <= 32'd0;
      rd_dat_q    <= '0;
      err_start_q <= 1'b0;
      err_stray_q <= 1'b0;
    end else begin
      ns_q        <= ns_d;
      base_q      <= base_d;
      strip_cnt_q <= strip_cnt_d;
      rd_we_q     <= rd_we_d;
      rd_strip_q  <= rd_strip_d;
      rd_adr_q    <= rd_adr_d;
      rd_dat_q    <= rd_dat_d;
      err_start_q <= err_start_d;
      err_stray_q <= err_stray_d;
    end
  end

  // outputs: busy/done decode the state, the rest come straight from registers
  always_comb begin
    bus.busy      = (state_q == S_COLLECT);
    bus.done      = (state_q == S_DONE);
    bus.strip_cnt = strip_cnt_q;
    bus.rd_we     = rd_we_q;
    bus.rd_strip  = rd_strip_q;
    bus.rd_adr    = rd_adr_q;
    bus.rd_dat    = rd_dat_q;
    bus.err_start = err_start_q;
    bus.err_stray = err_stray_q;
  end

endmodule

// File: tb/tb_mpmc11_rd_strip_collect.sv
// tb/tb_mpmc11_rd_strip_collect.sv - randomized bench for mpmc11_rd_strip_collect against a request-level reference model
module tb_mpmc11_rd_strip_collect;

`ifdef MPMC11_RD_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 1023;
`endif

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  logic [5:0]  drv_ns;
  logic [31:0] drv_base;

  // reference model: a request is "total" strips, of which "recv" have landed
  bit          m_coll;
  int          m_total;
  int          m_recv;
  int          m_idle;
  logic [31:0] m_abase;
  bit          m_we;
  bit          m_done;
  logic [5:0]  m_strip;
  logic [31:0] m_adr;
  logic [255:0] m_dat;
  bit          m_es;
  bit          m_estray;
  bit          m_etmo;

  mpmc11_rd_strip_collect_if #(.DATA_WIDTH(256)) bus ();

  mpmc11_rd_strip_collect #(
    .DATA_WIDTH(256),
    .TIMEOUT   (TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_coll = 0; m_total = 0; m_recv = 0; m_idle = 0; m_abase = '0;
    m_we = 0; m_done = 0; m_strip = '0; m_adr = '0; m_dat = '0;
    m_es = 0; m_estray = 0; m_etmo = 0;
  endtask

  // one clock of the request-level rules, given what was presented this cycle
  task automatic model_step(input bit st, input bit v, input logic [255:0] d);
    m_we   = 0;
    m_done = 0;
    if (m_coll) begin
      if (st) m_es = 1;
      if (v) begin
        m_we    = 1;
        m_strip = 6'(m_recv);
        m_adr   = m_abase + 32'(m_recv) * 32'd32;
        m_dat   = d;
        m_recv++;
        m_idle  = 0;
        if (m_recv == m_total) begin
          m_coll = 0;
          m_done = 1;
        end
      end else begin
        m_idle++;
`ifdef MPMC11_RD_TIMEOUT_EN
        if (m_idle == TMO) begin
          m_coll = 0;
          m_done = 1;
          m_etmo = 1;
        end
`endif
      end
    end else begin
      if (st) begin
        m_coll   = 1;
        m_total  = int'(drv_ns) + 1;
        m_recv   = 0;
        m_idle   = 0;
        m_abase  = drv_base & 32'hFFFF_FFE0;
        m_es     = 0;
        m_estray = 0;
        m_etmo   = 0;
      end
      if (v) m_estray = 1;
    end
  endtask

  function automatic logic [5:0] exp_strip_cnt();
    if (m_total > 0 && m_recv == m_total) return 6'(m_total - 1);
    return 6'(m_recv);
  endfunction

  task automatic check_all();
    check("rd_we",       256'(bus.rd_we),       256'(m_we));
    check("done",        256'(bus.done),        256'(m_done));
    check("busy",        256'(bus.busy),        256'(m_coll));
    check("strip_cnt",   256'(bus.strip_cnt),   256'(exp_strip_cnt()));
    check("rd_strip",    256'(bus.rd_strip),    256'(m_strip));
    check("rd_adr",      256'(bus.rd_adr),      256'(m_adr));
    check("rd_dat",      bus.rd_dat,            m_dat);
    check("err_start",   256'(bus.err_start),   256'(m_es));
    check("err_stray",   256'(bus.err_stray),   256'(m_estray));
    check("err_timeout", 256'(bus.err_timeout), 256'(m_etmo));
  endtask

  // present inputs for one cycle, advance the model at the edge, compare 1ns later
  task automatic cyc(input bit st, input bit v);
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom();
    bus.start             = st;
    bus.num_strips        = drv_ns;
    bus.addr_base         = drv_base;
    bus.app_rd_data_valid = v;
    bus.app_rd_data       = d;
    @(posedge clk);
    model_step(st, v, d);
    #1;
    check_all();
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && m_coll; i++) cyc(1'b0, ($urandom_range(0, 3) != 0));
    check("drain_bound", 256'(m_coll), 256'(0));
    cyc(1'b0, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    model_reset();
    rst = 1'b0;
    drv_ns = '0;
    drv_base = '0;
    bus.start = 1'b0;
    bus.num_strips = '0;
    bus.addr_base = '0;
    bus.app_rd_data_valid = 1'b0;
    bus.app_rd_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all();
    rst = 1'b1;
    cyc(1'b0, 1'b0);

    // basic: four back-to-back beats
    drv_ns = 6'd3; drv_base = 32'h0000_1234;
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1);
    check("basic_adr0", 256'(bus.rd_adr), 256'(32'h1220));
    cyc(1'b0, 1'b1);
    check("basic_adr1", 256'(bus.rd_adr), 256'(32'h1240));
    cyc(1'b0, 1'b1);
    check("basic_adr2", 256'(bus.rd_adr), 256'(32'h1260));
    cyc(1'b0, 1'b1);
    check("basic_adr3", 256'(bus.rd_adr), 256'(32'h1280));
    check("basic_done_with_last", 256'({bus.done, bus.rd_we, bus.rd_strip}), 256'({1'b1, 1'b1, 6'd3}));
    cyc(1'b0, 1'b0);
    check("basic_busy_drop", 256'({bus.busy, bus.done}), 256'(0));

    // single strip with a gap
    drv_ns = 6'd0; drv_base = $urandom();
    cyc(1'b1, 1'b0);
    repeat (4) cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    check("single_adr", 256'(bus.rd_adr), 256'(drv_base & 32'hFFFF_FFE0));
    cyc(1'b0, 1'b0);

    // 64 strips with random gaps
    drv_ns = 6'd63; drv_base = $urandom();
    cyc(1'b1, 1'b0);
    for (int k = 0; k < 64; k++) begin
      repeat ($urandom_range(0, 2)) cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b1);
    end
    check("max_strip_cnt", 256'(bus.strip_cnt), 256'(6'd63));
    cyc(1'b0, 1'b0);

    // address wrap at the top of the 32-bit space
    drv_ns = 6'd1; drv_base = 32'hFFFF_FFE0;
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1);
    check("wrap_adr0", 256'(bus.rd_adr), 256'(32'hFFFF_FFE0));
    cyc(1'b0, 1'b1);
    check("wrap_adr1", 256'(bus.rd_adr), 256'(32'h0000_0000));
    cyc(1'b0, 1'b0);

    // errors: start mid-collect, stray beat, clear on next start
    drv_ns = 6'd2; drv_base = $urandom();
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b0);
    check("err_start_set", 256'(bus.err_start), 256'(1));
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    check("stray_no_we", 256'({bus.rd_we, bus.err_stray}), 256'({1'b0, 1'b1}));
    drv_ns = 6'd1; drv_base = $urandom();
    cyc(1'b1, 1'b0);
    check("errs_cleared", 256'({bus.err_start, bus.err_stray}), 256'(0));
    drain();
    cyc(1'b1, 1'b1);
    check("start_with_stray", 256'({bus.busy, bus.err_stray}), 256'({1'b1, 1'b1}));
    drain();

    // back-to-back: start presented during DONE
    drv_ns = 6'd1; drv_base = 32'h0000_4000;
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    drv_ns = 6'd1; drv_base = 32'h0000_8000;
    cyc(1'b1, 1'b0);
    check("b2b_busy", 256'(bus.busy), 256'(1));
    cyc(1'b0, 1'b1);
    check("b2b_adr", 256'(bus.rd_adr), 256'(32'h0000_8000));
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);

    // random traffic, including stray beats and stray starts
    for (int k = 0; k < 400; k++) begin
      drv_ns   = 6'($urandom_range(0, 7));
      drv_base = $urandom();
      cyc(($urandom_range(0, 9) == 0), ($urandom_range(0, 2) != 0));
    end
    drain();

    // watchdog: two beats then silence
    drv_ns = 6'd3; drv_base = $urandom();
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    repeat (20) cyc(1'b0, 1'b0);
`ifdef MPMC11_RD_TIMEOUT_EN
    check("tmo_state", 256'({bus.busy, bus.err_timeout, bus.strip_cnt}), 256'({1'b0, 1'b1, 6'd2}));
`else
    check("no_tmo_state", 256'({bus.busy, bus.err_timeout}), 256'({1'b1, 1'b0}));
`endif
    drain();

    // asynchronous reset after two of four beats
    drv_ns = 6'd3; drv_base = $urandom();
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    bus.start = 1'b0;
    bus.app_rd_data_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b1;
    repeat (3) cyc(1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
